// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - opcode encodings presented on the op bus
//   - FSM state encoding for hilo_unit
//   - MUL_ITERS: number of shift-add iterations in seq_multiplier
package hilo_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int unsigned MUL_ITERS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDivWait
  } hilo_state_e;

endpackage

// File: rtl/hilo_if.sv
// hilo_if: bundles the pipeline-side operation bus and the stream_divider handshake.
//   master: the environment (pipeline + divider) driving ops and divider results
//   slave : hilo_unit, driving busy, HI/LO and the divider request
interface hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_reminder;

  modport master (
    output op_valid, op, rs_val, rt_val, div_done, div_quotient, div_reminder,
    input  busy, hi, lo, div_start, div_dividend, div_divisor
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val, div_done, div_quotient, div_reminder,
    output busy, hi, lo, div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned WIDTH x WIDTH iterative shift-add multiplier.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : load operands and begin (ignored bookkeeping-wise if already running)
//   multiplicand : unsigned operand A, sampled with start
//   multiplier   : unsigned operand B, sampled with start
//   done         : one-cycle pulse, registered, MUL_ITERS edges after start
//   product      : 2*WIDTH-bit result, valid while done is high and held afterwards
module seq_multiplier
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(MUL_ITERS + 1);

  logic               running_q;
  logic               done_q;
  logic [CntW-1:0]    count_q;
  logic [WIDTH-1:0]   mcand_q;
  // Upper half accumulates partial sums; lower half starts as the multiplier and
  // shifts out one bit per iteration while product bits shift in.
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     sum;

  always_comb begin
    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      done_q    <= 1'b0;
      count_q   <= '0;
      mcand_q   <= multiplicand;
      prod_q    <= {{WIDTH{1'b0}}, multiplier};
    end else if (running_q) begin
      prod_q  <= {sum, prod_q[WIDTH-1:1]};
      count_q <= count_q + 1'b1;
      if (count_q == CntW'(MUL_ITERS - 1)) begin
        running_q <= 1'b0;
        done_q    <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: MIPS HI/LO owner. Runs MULT/MULTU on an internal shift-add multiplier and
// DIV/DIVU on an external stream_divider via a start/done handshake.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : hilo_if.slave
//     op_valid/op/rs_val/rt_val  operation in (accepted when op_valid && !busy)
//     busy                       registered stall, high while an operation is in flight
//     hi/lo                      HI/LO registers
//     div_start/div_dividend/div_divisor  divider request, held until div_done
//     div_done/div_quotient/div_reminder  divider result (unsigned magnitudes)
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  hilo_if.slave bus
);

  hilo_state_e        state_q;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               div_start_q;
  logic [WIDTH-1:0]   div_dividend_q;
  logic [WIDTH-1:0]   div_divisor_q;
  logic               res_neg_q;  // negate product / quotient
  logic               rem_neg_q;  // negate remainder (dividend was negative)

  logic               accept;
  logic               op_signed;
  logic               res_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] mul_fixed;

  assign accept    = bus.op_valid && !busy_q && (state_q == StIdle);
  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign res_neg   = op_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
  // Negating -2^(WIDTH-1) wraps back to itself, which is the correct unsigned magnitude.
  assign rs_mag    = (op_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign rt_mag    = (op_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
  assign mul_start = accept && ((bus.op == OP_MULT) || (bus.op == OP_MULTU));
  assign mul_fixed = res_neg_q ? -mul_product : mul_product;

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (rs_mag),
    .multiplier   (rt_mag),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      busy_q         <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      res_neg_q      <= 1'b0;
      rem_neg_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Clears the one-cycle busy left by a divide-by-zero.
          busy_q <= 1'b0;
          if (accept) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.rs_val;
              OP_MTLO: lo_q <= bus.rs_val;
              OP_MULT, OP_MULTU: begin
                res_neg_q <= res_neg;
                busy_q    <= 1'b1;
                state_q   <= StMul;
              end
              OP_DIV, OP_DIVU: begin
                busy_q <= 1'b1;
                if (bus.rt_val != '0) begin
                  div_start_q    <= 1'b1;
                  div_dividend_q <= rs_mag;
                  div_divisor_q  <= rt_mag;
                  res_neg_q      <= res_neg;
                  rem_neg_q      <= op_signed && bus.rs_val[WIDTH-1];
                  state_q        <= StDivWait;
                end
              end
              default: ;
            endcase
          end
        end
        StMul: begin
          if (mul_done) begin
            {hi_q, lo_q} <= mul_fixed;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        StDivWait: begin
          if (bus.div_done) begin
            div_start_q <= 1'b0;
            lo_q        <= res_neg_q ? -bus.div_quotient : bus.div_quotient;
            hi_q        <= rem_neg_q ? -bus.div_reminder : bus.div_reminder;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.div_start    = div_start_q;
  assign bus.div_dividend = div_dividend_q;
  assign bus.div_divisor  = div_divisor_q;

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multiply/divide front end for the MIPS execute stage. Owns the HI/LO registers, executes MULT/MULTU internally with an iterative shift-add multiplier, and drives the external `stream_divider` through its start/done handshake for DIV/DIVU. While an operation is in flight, `busy` stalls the pipeline.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  the operation on `op` is presented this cycle.
- `op`  in  3  opcode: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- `rs_val`  in  WIDTH  first operand (dividend, multiplicand, or MTHI/MTLO data).
- `rt_val`  in  WIDTH  second operand (divisor, multiplier).
- `busy`  out  1  registered; when high, the unit ignores new operations.
- `hi`  out  WIDTH  HI register; MFHI reads it directly.
- `lo`  out  WIDTH  LO register; MFLO reads it directly.
- `div_start`  out  1  request to `stream_divider`.
- `div_dividend`  out  WIDTH  unsigned dividend magnitude, held while `div_start` is high.
- `div_divisor`  out  WIDTH  unsigned divisor magnitude, held while `div_start` is high.
- `div_done`  in  1  divider result-valid strobe.
- `div_quotient`  in  WIDTH  unsigned quotient, valid when `div_done` is high.
- `div_reminder`  in  WIDTH  unsigned remainder, valid when `div_done` is high.

## Operation
Reset values:
- `hi` = `lo` = 0.
- `busy` = 0, `div_start` = 0, `div_dividend` = `div_divisor` = 0.
- FSM in `IDLE`.

Acceptance:
- An operation is accepted at an edge where `op_valid && !busy`.
- When `busy` is high, `op_valid` is ignored; no queueing.

FSM states: `IDLE`, `MUL`, `DIV_WAIT`.
- `IDLE`:
  - MTHI/MTLO: `hi`/`lo` <= `rs_val`; stay in `IDLE`; `busy` stays 0.
  - MULT/MULTU: latch the operand magnitudes and result sign; `busy` <= 1; go to `MUL`.
  - DIV/DIVU with `rt_val` != 0: `div_start` <= 1; drive the magnitudes on the divider operand ports; `busy` <= 1; go to `DIV_WAIT`.
  - DIV/DIVU with `rt_val` == 0: no divider request; HI/LO unchanged; `busy` high for exactly one cycle; stay in `IDLE`.
- `MUL`: 32 shift-add iterations, then a sign-fix write of {HI, LO}; `busy` <= 0; go to `IDLE`.
- `DIV_WAIT`: hold `div_start` and the operand ports stable until an edge samples `div_done` = 1. At that edge: `div_start` <= 0; LO <= sign-fixed quotient; HI <= sign-fixed remainder; `busy` <= 0; go to `IDLE`.

Arithmetic rules:
- Signed ops (MULT, DIV) take two's-complement magnitudes. The magnitude of -2^31 is 0x80000000 (unsigned).
- MULT: negate the 64-bit product if the operand signs differ.
- DIV: negate the quotient if the operand signs differ; negate the remainder if `rs_val` < 0. Results wrap modulo 2^32, so -2^31 / -1 gives LO = 0x80000000, HI = 0.
- Unsigned ops (MULTU, DIVU) use no sign handling.

Boundary conditions:
- `div_done` while not in `DIV_WAIT` is ignored.
- Asynchronous reset in any state returns every output to its reset value immediately. A `div_done` arriving after reset is ignored.
- `op_valid` arriving in the same cycle that `busy` falls is accepted at the next edge. This guarantees `div_start` is low for at least one cycle between requests.

## Timing
Operation accepted at edge N:
- MTHI/MTLO: register updated at edge N.
- MULT/MULTU: `busy` is high from edge N to edge N+33; HI/LO are written at edge N+33.
- DIV/DIVU: `div_start` and `busy` rise at edge N. At edge M, the first edge with `div_done` = 1, HI/LO are written and both `busy` and `div_start` fall. Latency is set by the divider.
- Divide by zero: `busy` is high from edge N to edge N+1.

## Structure
- Package `hilo_pkg`: opcode localparams (`OP_NOP` through `OP_MTLO`), FSM state encoding, and `MUL_ITERS` = 32.
- Sub-module `seq_multiplier`: unsigned 32x32 shift-add multiplier with `start`/`done` and a 64-bit product.
- Sign handling, the FSM and HI/LO stay in `hilo_unit`.

## Test plan
1. Reset -> `hi` = `lo` = 0, `busy` = 0, `div_start` = 0. Then MTHI 0x12345678 -> `hi` = 0x12345678 after one edge, `busy` never asserted.
2. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `busy` high for 33 cycles, then `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
3. MULT -3 × 7 -> `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
4. DIVU 30 / 7 with a `stream_divider` instance attached -> `div_start` held until `div_done`, then `lo` = 4, `hi` = 2. DIV -30 / 7 -> `lo` = 0xFFFFFFFC, `hi` = 0xFFFFFFFE.
5. DIV 5 / 0 -> `div_start` never rises, HI/LO unchanged, `busy` high for one cycle. MTLO issued while `busy` is high during a MULT -> ignored; `lo` still receives the product.
6. Reset asserted mid-`DIV_WAIT` -> `div_start` and `busy` drop without a clock edge. A later `div_done` pulse leaves `hi` = `lo` = 0.
